wbm_xfer64: RTL and testbench

- Pipelined Wishbone B4 bus master: the initiator for 64-bit pipelined memory responders such as the memdev64 RAM, with or without extra-clock stall.
- Accepts one block-transfer command (start address, word count, read or write, byte select) and issues back-to-back strobes, honouring stall.
- Tracks outstanding requests and counts acknowledges.
- Streams read data out, pulls write data in, and reports completion or bus error.

---
 rtl/wbm_pkg.sv | 21 ++
 rtl/wbm_xfer64.sv | 211 +++++++++++++++++++++
 tb/tb_wbm_xfer64.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbm_pkg.sv
// rtl/wbm_pkg.sv - shared types and constants for the wbm_xfer64 Wishbone block-transfer master
//
// Contents:
//   wbm_state_e  transfer sequencer states (IDLE, ISSUE, DRAIN, FIN)
//   MAXOUT_LIMIT largest supported outstanding-request limit
//   OUT_W        width of the outstanding-request counter, sized for MAXOUT_LIMIT
package wbm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } wbm_state_e;

    // The outstanding counter is sized for the largest legal MAXOUT so one
    // width serves every instance of the master.
    localparam int MAXOUT_LIMIT = 15;
    localparam int OUT_W        = $clog2(MAXOUT_LIMIT + 1);

endpackage

// File: rtl/wbm_xfer64.sv
// rtl/wbm_xfer64.sv - pipelined Wishbone B4 master that runs one block read or write per command
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_cmd_*                 command: stb, we, first word addr, word count, byte select
//   o_busy, o_done, o_err   command in progress, completion pulse, bus-error flag
//   i_wr_valid/i_wr_data    write data source, consumed when o_wr_ready=1
//   o_rd_valid/o_rd_data    read data, one pulse per acknowledged beat
//   o_wb_*, i_wb_*          Wishbone B4 pipelined master interface
module wbm_xfer64
    import wbm_pkg::*;
#(
    parameter int DW     = 64,
    parameter int AW     = 12,
    parameter int LW     = 8,
    parameter int MAXOUT = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,

    input  logic            i_cmd_stb,
    input  logic            i_cmd_we,
    input  logic [AW-1:0]   i_cmd_addr,
    input  logic [LW-1:0]   i_cmd_len,
    input  logic [DW/8-1:0] i_cmd_sel,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,

    input  logic            i_wr_valid,
    input  logic [DW-1:0]   i_wr_data,
    output logic            o_wr_ready,

    output logic            o_rd_valid,
    output logic [DW-1:0]   o_rd_data,

    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    localparam int SW = DW / 8;
    localparam int CW = LW + 1;

    wbm_state_e     state_q;
    logic [CW-1:0]  len_q;
    logic [CW-1:0]  req_cnt_q;
    logic [CW-1:0]  ack_cnt_q;
    logic [OUT_W-1:0] out_q;
    logic [AW-1:0]  nxt_addr_q;

    logic           busy_q, done_q, err_q;
    logic           rd_valid_q;
    logic [DW-1:0]  rd_data_q;
    logic           cyc_q, stb_q, we_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  data_q;
    logic [SW-1:0]  sel_q;

    logic           ack_in, err_in, accept;
    logic [OUT_W:0] committed;
    logic           room, slot_free, launch;
    logic           stb_d;
    logic [CW-1:0]  req_cnt_d, ack_cnt_d;
    logic [OUT_W-1:0] out_d;

    // Responses only count while the cycle is open.
    assign ack_in = i_wb_ack & cyc_q;
    assign err_in = i_wb_err & cyc_q;
    assign accept = stb_q & ~i_wb_stall;

    // A request sitting on the bus (stb high) is committed even though the
    // responder has not taken it yet; counting it keeps the number of
    // un-acked requests at or below MAXOUT once it is accepted.
    assign committed = {1'b0, out_q} + {{OUT_W{1'b0}}, stb_q};
    assign room      = (committed < (OUT_W+1)'(MAXOUT)) | ack_in;

    assign slot_free = (state_q == ISSUE) & (req_cnt_q < len_q) & room
                     & (~stb_q | ~i_wb_stall);
    assign launch    = slot_free & (~we_q | i_wr_valid);

    assign o_wr_ready = slot_free & we_q;

    always_comb begin
        stb_d     = launch | (stb_q & i_wb_stall);
        req_cnt_d = req_cnt_q + {{LW{1'b0}}, launch};
        ack_cnt_d = ack_cnt_q;
        if (ack_in && (ack_cnt_q < len_q)) begin
            ack_cnt_d = ack_cnt_q + 1'b1;
        end
        out_d = out_q;
        if (accept && !ack_in) begin
            out_d = out_q + 1'b1;
        end else if (!accept && ack_in && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            req_cnt_q  <= '0;
            ack_cnt_q  <= '0;
            out_q      <= '0;
            nxt_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= '0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;

            // The error beat carries no data, so it never produces o_rd_valid.
            if (ack_in && !we_q && !err_in) begin
                rd_data_q  <= i_wb_data;
                rd_valid_q <= 1'b1;
            end

            if (err_in) begin
                // Abandon the rest of the block immediately.
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0 | 1'b1;
                err_q   <= 1'b1;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_cmd_stb) begin
                            len_q      <= {1'b0, i_cmd_len};
                            we_q       <= i_cmd_we;
                            sel_q      <= i_cmd_sel;
                            nxt_addr_q <= i_cmd_addr;
                            req_cnt_q  <= '0;
                            ack_cnt_q  <= '0;
                            out_q      <= '0;
                            err_q      <= 1'b0;
                            busy_q     <= 1'b1;
                            if (i_cmd_len == '0) begin
                                state_q <= FIN;
                            end else begin
                                cyc_q   <= 1'b1;
                                state_q <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        stb_q     <= stb_d;
                        req_cnt_q <= req_cnt_d;
                        ack_cnt_q <= ack_cnt_d;
                        out_q     <= out_d;
                        if (launch) begin
                            addr_q     <= nxt_addr_q;
                            nxt_addr_q <= nxt_addr_q + 1'b1;
                            if (we_q) begin
                                data_q <= i_wr_data;
                            end
                        end
                        if ((req_cnt_d == len_q) && !stb_d) begin
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        ack_cnt_q <= ack_cnt_d;
                        out_q     <= out_d;
                        if (ack_cnt_d == len_q) begin
                            cyc_q   <= 1'b0;
                            state_q <= FIN;
                        end
                    end
                    FIN: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_data_q;
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = we_q;
    assign o_wb_addr  = addr_q;
    assign o_wb_data  = data_q;
    assign o_wb_sel   = sel_q;

endmodule

// File: tb/tb_wbm_xfer64.sv
// tb/tb_wbm_xfer64.sv - directed self-checking bench for wbm_xfer64
module tb_wbm_xfer64;

    localparam logic [63:0] WBASE = 64'h1111_2222_3333_0000;

    logic        clk;
    logic        i_reset_n;
    logic        i_cmd_stb, i_cmd_we;
    logic [11:0] i_cmd_addr;
    logic [7:0]  i_cmd_len;
    logic [7:0]  i_cmd_sel;
    logic        o_busy, o_done, o_err;
    logic        i_wr_valid;
    logic [63:0] i_wr_data;
    logic        o_wr_ready;
    logic        o_rd_valid;
    logic [63:0] o_rd_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [11:0] o_wb_addr;
    logic [63:0] o_wb_data;
    logic [7:0]  o_wb_sel;
    logic        i_wb_stall, i_wb_ack, i_wb_err;
    logic [63:0] i_wb_data;

    wbm_xfer64 #(.DW(64), .AW(12), .LW(8), .MAXOUT(2)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_cmd_stb(i_cmd_stb), .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr),
        .i_cmd_len(i_cmd_len), .i_cmd_sel(i_cmd_sel),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_data(i_wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] data;
    } pend_t;

    logic [63:0] mem [0:4095];
    pend_t       pend[$];
    logic [11:0] acc_q[$];
    logic [63:0] rd_q[$];

    int checks, errors;
    int ncyc;
    int stall_n, ack_dly, err_at, stall_cnt, ack_idx;
    int done_cnt, done_cyc, cyc_rise, cyc_fall, cyc_fall_cyc;
    int first_acc, last_acc, last_ack_cyc, err_cyc;
    int out_cnt, max_out, hold_viol, cmd_cyc;
    int wr_idx, wr_n;
    logic done_err, prev_cyc, was_stalled, wr_toggle, wr_phase, wr_take;
    logic [84:0] held;

    // Monitor and responder share one negedge process so sampling always
    // precedes the responder's drive decisions for the coming posedge.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_err = o_err;
            done_cyc = ncyc;
        end
        if (o_rd_valid) rd_q.push_back(o_rd_data);
        if (o_wb_cyc && !prev_cyc) cyc_rise = cyc_rise + 1;
        if (!o_wb_cyc && prev_cyc) begin
            cyc_fall = cyc_fall + 1;
            cyc_fall_cyc = ncyc;
        end
        prev_cyc = o_wb_cyc;
        if (wr_take) wr_idx = wr_idx + 1;
        if (was_stalled && o_wb_stb && ({o_wb_we, o_wb_addr, o_wb_data, o_wb_sel} !== held))
            hold_viol = hold_viol + 1;

        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        i_wb_stall = 1'b0;
        was_stalled = 1'b0;
        if (!o_wb_cyc) begin
            pend.delete();
            stall_cnt = 0;
            out_cnt = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == ncyc) begin
                ack_idx = ack_idx + 1;
                if (ack_idx == err_at) begin
                    i_wb_err = 1'b1;
                    err_cyc = ncyc;
                end else begin
                    i_wb_ack = 1'b1;
                    i_wb_data = pend[0].data;
                    last_ack_cyc = ncyc;
                end
                void'(pend.pop_front());
                out_cnt = out_cnt - 1;
            end
            if (o_wb_stb) begin
                if (stall_cnt < stall_n) begin
                    i_wb_stall = 1'b1;
                    stall_cnt = stall_cnt + 1;
                    was_stalled = 1'b1;
                    held = {o_wb_we, o_wb_addr, o_wb_data, o_wb_sel};
                end else begin
                    stall_cnt = 0;
                    acc_q.push_back(o_wb_addr);
                    if (first_acc < 0) first_acc = ncyc;
                    last_acc = ncyc;
                    out_cnt = out_cnt + 1;
                    if (out_cnt > max_out) max_out = out_cnt;
                    if (o_wb_we) begin
                        for (int b = 0; b < 8; b++)
                            if (o_wb_sel[b]) mem[o_wb_addr][b*8 +: 8] = o_wb_data[b*8 +: 8];
                    end
                    pend.push_back('{ncyc + ack_dly, mem[o_wb_addr]});
                end
            end
        end

        wr_phase = ~wr_phase;
        i_wr_valid = (wr_idx < wr_n) && (!wr_toggle || wr_phase);
        i_wr_data = WBASE + 64'(wr_idx);
        #1;
        wr_take = i_wr_valid & o_wr_ready;
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_mon(input int s_n, input int a_d, input int e_at);
        acc_q.delete();
        rd_q.delete();
        done_cnt = 0; done_err = 1'b0; cyc_rise = 0; cyc_fall = 0;
        first_acc = -1; last_acc = -1; max_out = 0; hold_viol = 0; ack_idx = 0;
        stall_n = s_n; ack_dly = a_d; err_at = e_at;
    endtask

    task automatic send_cmd(input logic we, input logic [11:0] addr, input logic [7:0] len,
                            input logic [7:0] sel);
        step();
        i_cmd_we = we; i_cmd_addr = addr; i_cmd_len = len; i_cmd_sel = sel;
        i_cmd_stb = 1'b1;
        cmd_cyc = ncyc;
        step();
        i_cmd_stb = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt < 1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt < 1) begin
            $display("FAIL %s_timeout: no o_done after %0d cycles", name, n);
            errors++;
        end
        step();
        step();
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_rd_valid, o_wr_ready} !== 7'b0) begin
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_rd_valid, o_wr_ready});
            errors++;
        end
        checks++;
        if ({o_wb_addr, o_wb_data, o_rd_data} !== '0) begin
            $display("FAIL reset_data: addr %h data %h rd %h want 0", o_wb_addr, o_wb_data, o_rd_data);
            errors++;
        end
        i_reset_n = 1'b1;
        step();
    endtask

    task automatic test_read8();
        clear_mon(0, 1, 0);
        send_cmd(1'b0, 12'h010, 8'd8, 8'hFF);
        wait_done("read8");
        checks++;
        if (acc_q.size() !== 8) begin
            $display("FAIL read8_reqs: got %0d want 8", acc_q.size()); errors++;
        end
        checks++;
        if (last_acc - first_acc !== 7) begin
            $display("FAIL read8_b2b: span %0d want 7", last_acc - first_acc); errors++;
        end
        for (int k = 0; k < 8 && k < acc_q.size(); k++) begin
            checks++;
            if (acc_q[k] !== 12'h010 + 12'(k)) begin
                $display("FAIL read8_addr%0d: got %h want %h", k, acc_q[k], 12'h010 + 12'(k)); errors++;
            end
        end
        checks++;
        if (rd_q.size() !== 8) begin
            $display("FAIL read8_rdcnt: got %0d want 8", rd_q.size()); errors++;
        end
        for (int k = 0; k < 8 && k < rd_q.size(); k++) begin
            checks++;
            if (rd_q[k] !== 64'hD000_0000_0000_0010 + 64'(k)) begin
                $display("FAIL read8_data%0d: got %h want %h", k, rd_q[k],
                         64'hD000_0000_0000_0010 + 64'(k)); errors++;
            end
        end
        checks++;
        if ({done_cnt, done_err} !== {32'd1, 1'b0}) begin
            $display("FAIL read8_done: cnt %0d err %b want 1/0", done_cnt, done_err); errors++;
        end
        checks++;
        if (cyc_fall_cyc !== last_ack_cyc + 1) begin
            $display("FAIL read8_cycdrop: fell at %0d want %0d", cyc_fall_cyc, last_ack_cyc + 1); errors++;
        end
    endtask

    task automatic test_write_wrap();
        clear_mon(2, 1, 0);
        wr_toggle = 1'b0; wr_take = 1'b0; wr_idx = 0; wr_n = 4;
        send_cmd(1'b1, 12'hFFE, 8'd4, 8'hFF);
        wait_done("wrap");
        wr_n = 0;
        checks++;
        if (acc_q.size() !== 4) begin
            $display("FAIL wrap_reqs: got %0d want 4", acc_q.size()); errors++;
        end else begin
            checks++;
            if ({acc_q[0], acc_q[1], acc_q[2], acc_q[3]} !== 48'hFFE_FFF_000_001) begin
                $display("FAIL wrap_addr: got %h %h %h %h want ffe fff 000 001",
                         acc_q[0], acc_q[1], acc_q[2], acc_q[3]); errors++;
            end
        end
        checks++;
        if (hold_viol !== 0) begin
            $display("FAIL wrap_hold: %0d changes during stall want 0", hold_viol); errors++;
        end
        checks++;
        if (last_acc - first_acc !== 9) begin
            $display("FAIL wrap_span: got %0d want 9", last_acc - first_acc); errors++;
        end
        checks++;
        if ({mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]} !==
            {64'h1111_2222_3333_0000, 64'h1111_2222_3333_0001,
             64'h1111_2222_3333_0002, 64'h1111_2222_3333_0003}) begin
            $display("FAIL wrap_readback: got %h %h %h %h", mem[12'hFFE], mem[12'hFFF],
                     mem[12'h000], mem[12'h001]); errors++;
        end
        checks++;
        if ({done_cnt, done_err} !== {32'd1, 1'b0}) begin
            $display("FAIL wrap_done: cnt %0d err %b want 1/0", done_cnt, done_err); errors++;
        end
    endtask

    task automatic test_maxout();
        clear_mon(0, 3, 0);
        send_cmd(1'b0, 12'h100, 8'd6, 8'hFF);
        wait_done("maxout");
        checks++;
        if (max_out !== 2) begin
            $display("FAIL maxout_peak: got %0d want 2", max_out); errors++;
        end
        checks++;
        if (last_acc - first_acc !== 9) begin
            $display("FAIL maxout_span: got %0d want 9", last_acc - first_acc); errors++;
        end
        checks++;
        if ({acc_q.size(), rd_q.size()} !== {32'd6, 32'd6}) begin
            $display("FAIL maxout_count: reqs %0d rd %0d want 6/6", acc_q.size(), rd_q.size()); errors++;
        end
        checks++;
        if (rd_q.size() == 6 && rd_q[5] !== 64'hD000_0000_0000_0105) begin
            $display("FAIL maxout_last: got %h want d000000000000105", rd_q[5]); errors++;
        end
    endtask

    task automatic test_write_toggle();
        clear_mon(0, 1, 0);
        wr_toggle = 1'b1; wr_take = 1'b0; wr_idx = 0; wr_n = 4;
        send_cmd(1'b1, 12'h020, 8'd4, 8'h0F);
        wait_done("toggle");
        wr_n = 0; wr_toggle = 1'b0;
        checks++;
        if (last_acc - first_acc !== 6) begin
            $display("FAIL toggle_span: got %0d want 6", last_acc - first_acc); errors++;
        end
        checks++;
        if ({cyc_rise, cyc_fall, done_cnt} !== {32'd1, 32'd1, 32'd1}) begin
            $display("FAIL toggle_cyc: rise %0d fall %0d done %0d want 1/1/1",
                     cyc_rise, cyc_fall, done_cnt); errors++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[12'h020 + 12'(k)] !== 64'hD000_0000_3333_0000 + 64'(k)) begin
                $display("FAIL toggle_mem%0d: got %h want %h", k, mem[12'h020 + 12'(k)],
                         64'hD000_0000_3333_0000 + 64'(k)); errors++;
            end
        end
    endtask

    task automatic test_err();
        clear_mon(0, 1, 3);
        send_cmd(1'b0, 12'h200, 8'd6, 8'hFF);
        wait_done("err");
        checks++;
        if (rd_q.size() !== 2) begin
            $display("FAIL err_rdcnt: got %0d want 2", rd_q.size()); errors++;
        end else begin
            checks++;
            if ({rd_q[0], rd_q[1]} !== {64'hD000_0000_0000_0200, 64'hD000_0000_0000_0201}) begin
                $display("FAIL err_rddata: got %h %h", rd_q[0], rd_q[1]); errors++;
            end
        end
        checks++;
        if ({done_cnt, done_err, o_err} !== {32'd1, 1'b1, 1'b1}) begin
            $display("FAIL err_done: cnt %0d err %b held %b want 1/1/1", done_cnt, done_err, o_err); errors++;
        end
        checks++;
        if ({cyc_fall_cyc, done_cyc} !== {err_cyc + 1, err_cyc + 1}) begin
            $display("FAIL err_timing: cyc fell %0d done %0d want %0d", cyc_fall_cyc, done_cyc, err_cyc + 1);
            errors++;
        end
        err_at = 0;
        clear_mon(0, 1, 0);
        send_cmd(1'b0, 12'h000, 8'd0, 8'hFF);
        checks++;
        if (o_err !== 1'b0) begin
            $display("FAIL err_clear: got %b want 0", o_err); errors++;
        end
        wait_done("errclr");
    endtask

    task automatic test_len0();
        clear_mon(0, 1, 0);
        send_cmd(1'b0, 12'h055, 8'd0, 8'hFF);
        wait_done("len0");
        checks++;
        if (done_cyc - cmd_cyc !== 2) begin
            $display("FAIL len0_latency: got %0d want 2", done_cyc - cmd_cyc); errors++;
        end
        checks++;
        if ({cyc_rise, acc_q.size(), done_err, o_busy} !== {32'd0, 32'd0, 1'b0, 1'b0}) begin
            $display("FAIL len0_nocyc: rise %0d reqs %0d err %b busy %b want 0/0/0/0",
                     cyc_rise, acc_q.size(), done_err, o_busy); errors++;
        end
    endtask

    task automatic test_reset_mid();
        clear_mon(0, 3, 0);
        send_cmd(1'b0, 12'h300, 8'd8, 8'hFF);
        repeat (2) step();
        checks++;
        if ({o_wb_cyc, o_busy} !== 2'b11) begin
            $display("FAIL rstmid_active: cyc/busy %b want 11", {o_wb_cyc, o_busy}); errors++;
        end
        #1 i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_busy} !== 3'b000) begin
            $display("FAIL rstmid_drop: cyc/stb/busy %b want 000", {o_wb_cyc, o_wb_stb, o_busy}); errors++;
        end
        repeat (2) step();
        i_reset_n = 1'b1;
        repeat (6) step();
        checks++;
        if ({done_cnt, o_wb_cyc} !== {32'd0, 1'b0}) begin
            $display("FAIL rstmid_nodone: done %0d cyc %b want 0/0", done_cnt, o_wb_cyc); errors++;
        end
    endtask

    initial begin
        checks = 0; errors = 0; ncyc = 0;
        i_reset_n = 1'b0;
        i_cmd_stb = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = '0; i_cmd_len = '0; i_cmd_sel = '0;
        i_wr_valid = 1'b0; i_wr_data = '0;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
        prev_cyc = 1'b0; was_stalled = 1'b0; held = '0;
        wr_toggle = 1'b0; wr_phase = 1'b0; wr_take = 1'b0; wr_idx = 0; wr_n = 0;
        stall_cnt = 0; out_cnt = 0; done_cyc = 0; cyc_fall_cyc = 0;
        last_ack_cyc = 0; err_cyc = 0; cmd_cyc = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 64'hD000_0000_0000_0000 | 64'(i);
        clear_mon(0, 1, 0);

        test_reset();
        test_read8();
        test_write_wrap();
        test_maxout();
        test_write_toggle();
        test_err();
        test_len0();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
